// File: rtl/score_board_multi_pkg.sv
// Shared constants and types for the multi-port register scoreboard.
package score_board_multi_pkg;

  localparam int SB_NUM_REGS = 32;
  localparam int SB_ADDR_W   = $clog2(SB_NUM_REGS);
  localparam int SB_POS_W    = 8;
  localparam int SB_FU_W     = 3;

  typedef logic bool_t;
  localparam bool_t TRUE  = 1'b1;
  localparam bool_t FALSE = 1'b0;

  typedef logic [SB_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic [SB_POS_W-1:0] pos;
    logic [SB_FU_W-1:0]  fu;
  } score_board_data_t;

endpackage

// File: rtl/score_board_multi_if.sv
// Issue-write and lookup bundle between the issue stage and the scoreboard.
interface score_board_multi_if #(
  parameter int NUM_REGS = score_board_multi_pkg::SB_NUM_REGS,
  parameter int NUM_WR   = 4,
  parameter int NUM_RD   = 8,
  parameter int POS_W    = score_board_multi_pkg::SB_POS_W,
  parameter int FU_W     = score_board_multi_pkg::SB_FU_W
);
  import score_board_multi_pkg::*;

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                               stall;
  logic                               flush;
  logic [NUM_WR-1:0]                  wr_ena;
  logic [NUM_WR-1:0][ADDR_W-1:0]      wr_addr;
  logic [NUM_WR-1:0][POS_W-1:0]       wr_pos;
  logic [NUM_WR-1:0][FU_W-1:0]        wr_fu;
  logic [NUM_RD-1:0][ADDR_W-1:0]      rd_addr;
  logic [NUM_RD-1:0][POS_W-1:0]       rd_pos;
  logic [NUM_RD-1:0][FU_W-1:0]        rd_fu;
  logic [NUM_RD-1:0]                  rd_busy;
  logic [ADDR_W:0]                    busy_count;

  modport master (
    output stall, flush, wr_ena, wr_addr, wr_pos, wr_fu, rd_addr,
    input  rd_pos, rd_fu, rd_busy, busy_count
  );

  modport slave (
    input  stall, flush, wr_ena, wr_addr, wr_pos, wr_fu, rd_addr,
    output rd_pos, rd_fu, rd_busy, busy_count
  );

endinterface

// File: rtl/score_board_entry.sv
// One scoreboard entry: flush > write > stall > shift-right priority, plus state.
module score_board_entry #(
  parameter int POS_W = score_board_multi_pkg::SB_POS_W,
  parameter int FU_W  = score_board_multi_pkg::SB_FU_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  hit,
  input  logic [POS_W+FU_W-1:0] wdata,
  output logic [POS_W-1:0]      pos,
  output logic [FU_W-1:0]       fu,
  output logic [POS_W-1:0]      pos_next
);
  import score_board_multi_pkg::*;

  logic [POS_W-1:0] pos_reg;
  logic [FU_W-1:0]  fu_reg;
  logic [FU_W-1:0]  fu_next;

  // Flush only clears the position; the producer tag is left for debug visibility.
  always_comb begin
    pos_next = pos_reg;
    fu_next  = fu_reg;
    if (flush) begin
      pos_next = '0;
    end else if (hit) begin
      pos_next = wdata[POS_W+FU_W-1:FU_W];
      fu_next  = wdata[FU_W-1:0];
    end else if (!stall) begin
      pos_next = pos_reg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_reg <= '0;
      fu_reg  <= '0;
    end else begin
      pos_reg <= pos_next;
      fu_reg  <= fu_next;
    end
  end

  assign pos = pos_reg;
  assign fu  = fu_reg;

endmodule

// File: rtl/score_board_multi.sv
// Multi-port register scoreboard: per-register position shifters, read muxes
// and a registered busy-entry count. Register 0 is hard-wired idle.
module score_board_multi #(
  parameter int NUM_REGS = score_board_multi_pkg::SB_NUM_REGS,
  parameter int NUM_WR   = 4,
  parameter int NUM_RD   = 8,
  parameter int POS_W    = score_board_multi_pkg::SB_POS_W,
  parameter int FU_W     = score_board_multi_pkg::SB_FU_W
) (
  input logic               clk,
  input logic               rst,
  score_board_multi_if.slave sb
);
  import score_board_multi_pkg::*;

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int DATA_W = POS_W + FU_W;

  logic [NUM_REGS-1:0][POS_W-1:0] pos_q;
  logic [NUM_REGS-1:0][FU_W-1:0]  fu_q;
  logic [NUM_REGS-1:0]            busy_next;
  logic [ADDR_W:0]                busy_count_reg;
  logic [ADDR_W:0]                busy_count_next;

  assign pos_q[0]     = '0;
  assign fu_q[0]      = '0;
  assign busy_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      bool_t             hit;
      logic [DATA_W-1:0] wdata;
      logic [POS_W-1:0]  pos_nxt;

      // Ascending scan so the highest-indexed matching port wins.
      always_comb begin
        hit   = FALSE;
        wdata = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (sb.wr_ena[p] && (sb.wr_addr[p] == ADDR_W'(gi))) begin
            hit   = TRUE;
            wdata = {sb.wr_pos[p], sb.wr_fu[p]};
          end
        end
      end

      score_board_entry #(
        .POS_W (POS_W),
        .FU_W  (FU_W)
      ) u_entry (
        .clk      (clk),
        .rst      (rst),
        .flush    (sb.flush),
        .stall    (sb.stall),
        .hit      (hit),
        .wdata    (wdata),
        .pos      (pos_q[gi]),
        .fu       (fu_q[gi]),
        .pos_next (pos_nxt)
      );

      assign busy_next[gi] = |pos_nxt;
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_read
      assign sb.rd_pos[gi]  = pos_q[sb.rd_addr[gi]];
      assign sb.rd_fu[gi]   = fu_q[sb.rd_addr[gi]];
      assign sb.rd_busy[gi] = |pos_q[sb.rd_addr[gi]];
    end
  endgenerate

  // Counted from next-state so the count lines up with rd_* after the same edge.
  always_comb begin
    busy_count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_next = busy_count_next + (ADDR_W+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_count_reg <= '0;
    end else begin
      busy_count_reg <= busy_count_next;
    end
  end

  assign sb.busy_count = busy_count_reg;

endmodule

// File: tb/tb_score_board_multi.sv
// Directed self-checking bench for score_board_multi.
module tb_score_board_multi;
  import score_board_multi_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  score_board_multi_if #(
    .NUM_REGS (32), .NUM_WR (4), .NUM_RD (8), .POS_W (8), .FU_W (3)
  ) sb ();

  score_board_multi #(
    .NUM_REGS (32), .NUM_WR (4), .NUM_RD (8), .POS_W (8), .FU_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    sb.wr_ena  = '0;
    sb.wr_addr = '0;
    sb.wr_pos  = '0;
    sb.wr_fu   = '0;
  endtask

  task automatic set_wr(input int p, input int addr, input logic [7:0] pos, input logic [2:0] fu);
    sb.wr_ena[p]  = 1'b1;
    sb.wr_addr[p] = 5'(addr);
    sb.wr_pos[p]  = pos;
    sb.wr_fu[p]   = fu;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sb.stall = 1'b0;
    sb.flush = 1'b0;
    clear_writes();
    for (int r = 0; r < 8; r++) sb.rd_addr[r] = 5'(r + 1);
    tick();
    tick();
    checks++;
    if (sb.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", sb.busy_count);
    end
    checks++;
    if (sb.rd_busy !== 8'h00) begin
      errors++;
      $display("FAIL reset_busy: got %h expected 00", sb.rd_busy);
    end
    rst = 1'b1;
    tick();
    $display("reset released: busy_count=%0d rd_busy=%h", sb.busy_count, sb.rd_busy);
  endtask

  task automatic test_single_write();
    logic [7:0] exp_pos;
    set_wr(0, 5, 8'h80, 3'd2);
    sb.rd_addr[0] = 5'd5;
    tick();
    clear_writes();
    checks++;
    if (sb.rd_pos[0] !== 8'h80 || sb.rd_busy[0] !== 1'b1 || sb.rd_fu[0] !== 3'd2) begin
      errors++;
      $display("FAIL single_write: got pos=%h busy=%b fu=%0d expected pos=80 busy=1 fu=2",
               sb.rd_pos[0], sb.rd_busy[0], sb.rd_fu[0]);
    end
    checks++;
    if (sb.busy_count !== 6'd1) begin
      errors++;
      $display("FAIL single_count: got %0d expected 1", sb.busy_count);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_pos = 8'h80 >> k;
      checks++;
      if (sb.rd_pos[0] !== exp_pos) begin
        errors++;
        $display("FAIL shift_%0d: got %h expected %h", k, sb.rd_pos[0], exp_pos);
      end
      $display("shift %0d: r5 pos=%h busy_count=%0d", k, sb.rd_pos[0], sb.busy_count);
    end
    checks++;
    if (sb.rd_busy[0] !== 1'b0 || sb.busy_count !== 6'd0 || sb.rd_fu[0] !== 3'd2) begin
      errors++;
      $display("FAIL drained: got busy=%b count=%0d fu=%0d expected busy=0 count=0 fu=2",
               sb.rd_busy[0], sb.busy_count, sb.rd_fu[0]);
    end
  endtask

  task automatic test_conflict();
    set_wr(0, 7, 8'h80, 3'd1);
    set_wr(3, 7, 8'h04, 3'd5);
    sb.rd_addr[1] = 5'd7;
    tick();
    clear_writes();
    checks++;
    if (sb.rd_pos[1] !== 8'h04 || sb.rd_fu[1] !== 3'd5 || sb.busy_count !== 6'd1) begin
      errors++;
      $display("FAIL conflict: got pos=%h fu=%0d count=%0d expected pos=04 fu=5 count=1",
               sb.rd_pos[1], sb.rd_fu[1], sb.busy_count);
    end
    $display("conflict: r7 pos=%h fu=%0d", sb.rd_pos[1], sb.rd_fu[1]);
    tick();
    tick();
    tick();
    checks++;
    if (sb.rd_pos[1] !== 8'h00 || sb.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL conflict_drain: got pos=%h count=%0d expected 00 0", sb.rd_pos[1], sb.busy_count);
    end
  endtask

  task automatic test_stall();
    sb.rd_addr[2] = 5'd3;
    sb.rd_addr[3] = 5'd4;
    set_wr(1, 3, 8'h10, 3'd3);
    tick();
    clear_writes();
    sb.stall = 1'b1;
    tick();
    set_wr(2, 4, 8'h02, 3'd4);
    tick();
    clear_writes();
    tick();
    checks++;
    if (sb.rd_pos[2] !== 8'h10 || sb.rd_pos[3] !== 8'h02 || sb.busy_count !== 6'd2) begin
      errors++;
      $display("FAIL stall_hold: got r3=%h r4=%h count=%0d expected 10 02 2",
               sb.rd_pos[2], sb.rd_pos[3], sb.busy_count);
    end
    $display("stalled: r3=%h r4=%h", sb.rd_pos[2], sb.rd_pos[3]);
    sb.stall = 1'b0;
    tick();
    checks++;
    if (sb.rd_pos[2] !== 8'h08 || sb.rd_pos[3] !== 8'h01) begin
      errors++;
      $display("FAIL stall_release: got r3=%h r4=%h expected 08 01", sb.rd_pos[2], sb.rd_pos[3]);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (sb.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL stall_drain: got %0d expected 0", sb.busy_count);
    end
  endtask

  task automatic test_flush();
    sb.rd_addr[4] = 5'd9;
    sb.rd_addr[5] = 5'd13;
    set_wr(0, 9, 8'h80, 3'd6);
    set_wr(1, 10, 8'h80, 3'd1);
    set_wr(2, 11, 8'h80, 3'd1);
    set_wr(3, 12, 8'h80, 3'd1);
    tick();
    clear_writes();
    set_wr(0, 13, 8'h80, 3'd2);
    set_wr(1, 14, 8'h80, 3'd2);
    tick();
    clear_writes();
    checks++;
    if (sb.busy_count !== 6'd6) begin
      errors++;
      $display("FAIL flush_setup: got %0d expected 6", sb.busy_count);
    end
    sb.flush = 1'b1;
    set_wr(3, 9, 8'hFF, 3'd1);
    tick();
    sb.flush = 1'b0;
    clear_writes();
    checks++;
    if (sb.rd_pos[4] !== 8'h00 || sb.rd_fu[4] !== 3'd6 || sb.rd_busy[5] !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: got r9 pos=%h fu=%0d r13 busy=%b expected 00 6 0",
               sb.rd_pos[4], sb.rd_fu[4], sb.rd_busy[5]);
    end
    checks++;
    if (sb.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL flush_count: got %0d expected 0", sb.busy_count);
    end
    $display("flush: r9 pos=%h fu=%0d count=%0d", sb.rd_pos[4], sb.rd_fu[4], sb.busy_count);
  endtask

  task automatic test_r0_mixed();
    set_wr(0, 0, 8'hFF, 3'd1);
    set_wr(1, 1, 8'hFF, 3'd2);
    set_wr(2, 2, 8'hFF, 3'd3);
    set_wr(3, 31, 8'hFF, 3'd4);
    sb.rd_addr[0] = 5'd0;
    sb.rd_addr[1] = 5'd1;
    sb.rd_addr[2] = 5'd2;
    sb.rd_addr[3] = 5'd31;
    sb.rd_addr[4] = 5'd9;
    sb.rd_addr[5] = 5'd5;
    sb.rd_addr[6] = 5'd7;
    sb.rd_addr[7] = 5'd3;
    tick();
    clear_writes();
    checks++;
    if (sb.rd_pos[0] !== 8'h00 || sb.rd_fu[0] !== 3'd0) begin
      errors++;
      $display("FAIL r0_state: got pos=%h fu=%0d expected 00 0", sb.rd_pos[0], sb.rd_fu[0]);
    end
    checks++;
    if (sb.busy_count !== 6'd3) begin
      errors++;
      $display("FAIL r0_count: got %0d expected 3", sb.busy_count);
    end
    checks++;
    if (sb.rd_busy !== 8'b0000_1110) begin
      errors++;
      $display("FAIL mixed_busy: got %b expected 00001110", sb.rd_busy);
    end
    checks++;
    if (sb.rd_pos[3] !== 8'hFF || sb.rd_fu[3] !== 3'd4) begin
      errors++;
      $display("FAIL mixed_r31: got pos=%h fu=%0d expected FF 4", sb.rd_pos[3], sb.rd_fu[3]);
    end
    $display("mixed: rd_busy=%b count=%0d", sb.rd_busy, sb.busy_count);
  endtask

  task automatic test_async_reset();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (sb.rd_pos[1] !== 8'h00 || sb.rd_busy !== 8'h00 || sb.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL async_reset: got r1=%h busy=%b count=%0d expected 00 00000000 0",
               sb.rd_pos[1], sb.rd_busy, sb.busy_count);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (sb.rd_pos[1] !== 8'h00 || sb.rd_fu[3] !== 3'd0 || sb.busy_count !== 6'd0) begin
      errors++;
      $display("FAIL post_reset: got r1=%h r31 fu=%0d count=%0d expected 00 0 0",
               sb.rd_pos[1], sb.rd_fu[3], sb.busy_count);
    end
    $display("async reset: rd_busy=%b count=%0d", sb.rd_busy, sb.busy_count);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_write();
    test_conflict();
    test_stall();
    test_flush();
    test_r0_mixed();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_board_multi.md
Name: score_board_multi

Overview:
- Parametrised, multi-port register scoreboard for the superscalar issue stage.
- Each architectural register holds a one-hot/thermometer "position" shift vector that records when its in-flight result reaches a forwardable stage, plus the tag of the producing functional unit.
- Issue writes new entries; all other entries shift right one stage per unstalled cycle.
- Adds stall freeze, global flush, deterministic same-address priority, an r0 hard-wire and a busy-register count.

Parameters:
- NUM_REGS, 32: number of architectural registers; power of two.
- NUM_WR, 4: issue/write ports.
- NUM_RD, 8: lookup ports (2 per issue slot).
- POS_W, 8: position vector width = max pipeline depth tracked.
- FU_W, 3: functional-unit tag width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  1  freeze shifting of non-written entries
- flush  in  1  clear all entries next edge
- wr_ena  in  NUM_WR  per-port write valid
- wr_addr  in  NUM_WR x log2(NUM_REGS)  destination register
- wr_pos  in  NUM_WR x POS_W  initial position vector
- wr_fu  in  NUM_WR x FU_W  producing unit tag
- rd_addr  in  NUM_RD x log2(NUM_REGS)  lookup register
- rd_pos  out  NUM_RD x POS_W  current position of rd_addr
- rd_fu  out  NUM_RD x FU_W  current tag of rd_addr
- rd_busy  out  NUM_RD  rd_pos != 0
- busy_count  out  log2(NUM_REGS)+1  number of entries with position != 0

Behaviour:
- Reset: rst=0 asynchronously clears every entry (pos=0, fu=0) and forces busy_count=0.
  - While rst=0, rd_pos, rd_fu and rd_busy read 0.
  - First write is accepted on the first rising edge with rst=1.
- State per entry i: pos[i] (POS_W bits), fu[i] (FU_W bits).
- Reads:
  - Purely combinational from the registered state; no bypass of same-cycle writes.
  - A write issued in cycle N is visible on rd_* in cycle N+1.
- Next-state per entry, evaluated in priority order:
  1. flush=1: pos=0, fu unchanged. Overrides writes and stall.
  2. Entry written by a valid port (wr_ena[p]=1, wr_addr[p]=i, i!=0): pos=wr_pos[p], fu=wr_fu[p].
     - Several ports to the same address: highest port index wins (youngest in bundle).
  3. stall=1: hold.
  4. Otherwise: pos = pos >> 1 (zero fill); fu holds.
- Writes during stall are still accepted.
- Once pos reaches 0 it stays 0; the entry is idle.
- r0: writes to address 0 are dropped; pos[0]=0 and fu[0]=0 permanently; rd_busy for address 0 is always 0.
- wr_pos=0 is legal and marks the register immediately idle, while fu is still updated.
- busy_count:
  - Registered; equals the popcount of pos != 0 over the state after the edge.
  - Updates in the same edge as the entries, so it is consistent with rd_* in the following cycle.
  - Range 0..NUM_REGS-1 (r0 never counted).
- No handshake and no back-pressure; every write is accepted in one cycle.
- Latency: write to read = 1 cycle. Shift rate: 1 bit per unstalled cycle.

Decomposition:
- Shared package (defines):
  - SB_POS_W and SB_FU_W defaults.
  - SCORE_BOARD_DATA struct {pos, fu} sized from those constants.
  - REG_ADDR typedef; the bool/true/false convention is reused.
- Sub-module score_board_entry, instantiated NUM_REGS-1 times (r0 tied off).
  - Inputs: flush, stall, hit, wdata.
  - Contains the priority mux and shifter.
- Top level holds:
  - per-entry port-select logic (highest-index hit encoder),
  - read muxes,
  - popcount register.

Test Plan:
- Reset then idle: pulse rst=0 mid-run with entries busy -> rd_pos=0 immediately (async), busy_count=0; after release, all reads 0.
- Single write and shift: port0 writes r5, pos=8'b1000_0000, fu=2.
  - rd r5 next cycle = 8'h80, busy=1, fu=2.
  - Then 8'h40, 8'h20, ...; after 8 unstalled cycles pos=0, busy=0, busy_count back to 0.
- Same-address conflict: ports 0 and 3 both write r7, port0 pos=8'h80 fu=1, port3 pos=8'h04 fu=5 -> next cycle rd r7 pos=8'h04, fu=5, busy_count=1.
- Stall: r3 at pos=8'h10, stall=1 for 3 cycles -> remains 8'h10.
  - A write to r4 (8'h02) during the stall lands; on release, r3=8'h08 and r4=8'h01.
- Flush precedence: flush=1 with simultaneous write to r9 and 6 busy regs -> next cycle all pos=0 (r9 included), busy_count=0, and fu of r9 keeps its old value.
- r0 and mixed ports: all four ports write r0, r1, r2, r31 with pos=8'hFF -> r0 reads 0, busy_count=3, and rd_busy is correct on all 8 read ports when each reads a different register.
